muldiv_unit: RTL and testbench

- Multi-cycle RISC-V M-extension execute unit. Decodes funct3 for the eight OP/funct7=0000001 operations: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Executes them with a parametrised-width datapath. Multiply is single-cycle or iterative; divide is radix-2 restoring.
- Sits beside the main ALU in the execute stage. Holds its operation and stalls the pipeline through valid/ready handshakes on both sides.
- Supports a flush for branch mispredicts.

---
 rtl/muldiv_unit_if.sv | 27 ++
 rtl/muldiv_unit.sv | 132 +++++++++++++
 tb/tb_muldiv_unit.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/result handshake bundle for the multiply/divide unit
interface muldiv_unit_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             valid_i;
  logic             ready_o;
  logic [2:0]       funct3_i;
  logic [WIDTH-1:0] op_a_i;
  logic [WIDTH-1:0] op_b_i;
  logic [TAG_W-1:0] tag_i;
  logic             flush_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] result_o;
  logic [TAG_W-1:0] tag_o;

  modport master (
    output valid_i, funct3_i, op_a_i, op_b_i, tag_i, flush_i, ready_i,
    input  ready_o, valid_o, result_o, tag_o
  );

  modport slave (
    input  valid_i, funct3_i, op_a_i, op_b_i, tag_i, flush_i, ready_i,
    output ready_o, valid_o, result_o, tag_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle RISC-V M-extension multiply/divide execute unit
module muldiv_unit #(
  parameter int WIDTH    = 32,
  parameter bit FAST_MUL = 1'b1,
  parameter int TAG_W    = 5
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state, state_nxt;
  logic [2:0]         fn;
  logic               a_s, b_s, sp;
  logic [2*WIDTH-1:0] am;
  logic [WIDTH-1:0]   bm;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;

  logic accept;
  assign accept      = bus.valid_i & bus.ready_o & ~bus.flush_i;
  assign bus.ready_o = (state == IDLE);
  assign bus.valid_o = (state == DONE);

  // Decode of the incoming request: operand signedness, magnitudes and one-cycle special cases
  logic [2:0]       f;
  logic             in_div, in_a_s, in_b_s, in_sp;
  logic [WIDTH-1:0] in_am, in_bm;
  assign f      = bus.funct3_i;
  assign in_div = f[2];
  assign in_a_s = bus.op_a_i[WIDTH-1] &
                  (f == 3'b001 || f == 3'b010 || f == 3'b100 || f == 3'b110);
  assign in_b_s = bus.op_b_i[WIDTH-1] & (f == 3'b001 || f == 3'b100 || f == 3'b110);
  assign in_am  = in_a_s ? -bus.op_a_i : bus.op_a_i;
  assign in_bm  = in_b_s ? -bus.op_b_i : bus.op_b_i;
  assign in_sp  = in_div & ((bus.op_b_i == '0) |
                  (~f[0] & (bus.op_a_i == MIN_NEG) & (&bus.op_b_i)));

  // One shift-add step and one restoring-division step
  logic [2*WIDTH-1:0] mul_acc_nxt, div_acc_nxt;
  logic [WIDTH:0]     rem_sh, diff;
  assign mul_acc_nxt = bm[0] ? acc + am : acc;
  assign rem_sh      = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign diff        = rem_sh - {1'b0, bm};
  assign div_acc_nxt = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                   : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  // Finalisation: sign correction and high/low or quotient/remainder select
  logic [2*WIDTH-1:0] fast_prod, prod_raw, prod;
  logic [WIDTH-1:0]   mul_res, div_res, fin_res, a_orig, quo, rem;
  assign fast_prod = {{WIDTH{1'b0}}, am[WIDTH-1:0]} * {{WIDTH{1'b0}}, bm};
  assign prod_raw  = FAST_MUL ? fast_prod : acc;
  assign prod      = (a_s ^ b_s) ? -prod_raw : prod_raw;
  assign mul_res   = (fn[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
  assign a_orig    = a_s ? -am[WIDTH-1:0] : am[WIDTH-1:0];
  assign quo       = (a_s ^ b_s) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem       = a_s ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  // Special-case divides bypass the quotient logic; zero divisor and overflow differ per op
  always_comb begin
    div_res = fn[1] ? rem : quo;
    if (sp) begin
      if (bm == '0) div_res = fn[1] ? a_orig : '1;
      else          div_res = fn[1] ? '0 : a_orig;
    end
    fin_res = fn[2] ? div_res : mul_res;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; flush returns to IDLE from anywhere
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = in_div ? DIV : MUL;
      MUL,
      DIV:     if (cnt == CNT_END) state_nxt = DONE;
      DONE:    if (bus.ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush_i) state_nxt = IDLE;
  end

  // Datapath: capture on accept, iterate until the counter ends, then finalise into result_o.
  // Fast multiplies and special divides preload the counter so only the finalisation edge runs.
  always_ff @(posedge clk) begin
    if (rst) begin
      fn           <= '0;
      a_s          <= 1'b0;
      b_s          <= 1'b0;
      sp           <= 1'b0;
      am           <= '0;
      bm           <= '0;
      acc          <= '0;
      cnt          <= '0;
      bus.result_o <= '0;
      bus.tag_o    <= '0;
    end else if (accept) begin
      fn        <= f;
      a_s       <= in_a_s;
      b_s       <= in_b_s;
      sp        <= in_sp;
      am        <= {{WIDTH{1'b0}}, in_am};
      bm        <= in_bm;
      acc       <= in_div ? {{WIDTH{1'b0}}, in_am} : '0;
      cnt       <= (in_sp || (!in_div && FAST_MUL)) ? CNT_END : '0;
      bus.tag_o <= bus.tag_i;
    end else if ((state == MUL || state == DIV) && !bus.flush_i) begin
      if (cnt != CNT_END) begin
        cnt <= cnt + 1'b1;
        if (state == MUL) begin
          acc <= mul_acc_nxt;
          am  <= am << 1;
          bm  <= bm >> 1;
        end else begin
          acc <= div_acc_nxt;
        end
      end else begin
        bus.result_o <= fin_res;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench running a fast and an iterative unit side by side
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0, flush_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] op_a_i = '0, op_b_i = '0;
  logic [4:0]  tag_i = '0;
  logic        bp_force = 1'b1, bp_val = 1'b1, rnd_bit = 1'b1, rdy;
  int          cyc = 0;
  int          pass = 0, total = 0;

  always #5 clk = ~clk;

  assign rdy = bp_force ? bp_val : rnd_bit;

  muldiv_unit_if #(.WIDTH(32), .TAG_W(5)) bf ();
  muldiv_unit_if #(.WIDTH(32), .TAG_W(5)) bs ();

  assign bf.valid_i = valid_i;  assign bs.valid_i = valid_i;
  assign bf.funct3_i = funct3_i; assign bs.funct3_i = funct3_i;
  assign bf.op_a_i = op_a_i;    assign bs.op_a_i = op_a_i;
  assign bf.op_b_i = op_b_i;    assign bs.op_b_i = op_b_i;
  assign bf.tag_i = tag_i;      assign bs.tag_i = tag_i;
  assign bf.flush_i = flush_i;  assign bs.flush_i = flush_i;
  assign bf.ready_i = rdy;      assign bs.ready_i = rdy;

  muldiv_unit #(.WIDTH(32), .FAST_MUL(1'b1), .TAG_W(5)) dut_fast (.clk(clk), .rst(rst), .bus(bf));
  muldiv_unit #(.WIDTH(32), .FAST_MUL(1'b0), .TAG_W(5)) dut_slow (.clk(clk), .rst(rst), .bus(bs));

  logic        vo [2];
  logic        rdo [2];
  logic [31:0] ro [2];
  logic [4:0]  tgo [2];
  assign vo[0] = bf.valid_o;   assign vo[1] = bs.valid_o;
  assign rdo[0] = bf.ready_o;  assign rdo[1] = bs.ready_o;
  assign ro[0] = bf.result_o;  assign ro[1] = bs.result_o;
  assign tgo[0] = bf.tag_o;    assign tgo[1] = bs.tag_o;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          lat;
    int          acc;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  typedef struct {
    logic [2:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;
  vec_t dir [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] fn, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb, sp;
    longint unsigned up;
    logic [63:0]     w;
    int              ia, ib;
    logic [31:0]     r;
    logic            ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ia  = $signed(a);
    ib  = $signed(b);
    up  = {32'h0, a} * {32'h0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = '0;
    case (fn)
      3'd0: begin w = up; r = w[31:0]; end
      3'd1: begin sp = sa * sb; w = sp; r = w[63:32]; end
      3'd2: begin sp = sa * longint'({32'h0, b}); w = sp; r = w[63:32]; end
      3'd3: begin w = up; r = w[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] fn, input logic [31:0] a,
                                 input logic [31:0] b, input bit fast);
    if (!fn[2]) return fast ? 1 : 33;
    if (b == 0) return 1;
    if (!fn[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tg, input logic [31:0] res, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    while (!(rdo[0] && rdo[1]) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      chk("issue_ready_timeout", 64'd0, 64'd1);
      return;
    end
    valid_i = 1'b1; funct3_i = fn; op_a_i = a; op_b_i = b; tag_i = tg;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    if (push) begin
      q0.push_back('{res, tg, exp_lat(fn, a, b, 1'b1), cyc});
      q1.push_back('{res, tg, exp_lat(fn, a, b, 1'b0), cyc});
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(q0.size() + q1.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic watch_quiet(input string nm, input int cycles);
    bit saw;
    saw = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (vo[0] || vo[1]) saw = 1'b1;
    end
    chk(nm, 64'(saw), 64'd0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    rnd_bit = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops one expectation per rising valid_o and checks value, tag and latency
  initial begin
    bit   seen [2];
    exp_t e;
    int   qs;
    seen[0] = 1'b0;
    seen[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!vo[d]) seen[d] = 1'b0;
        else if (!seen[d]) begin
          seen[d] = 1'b1;
          qs = (d == 0) ? q0.size() : q1.size();
          if (qs == 0) chk($sformatf("unexpected_valid_d%0d", d), 64'd1, 64'd0);
          else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("result_d%0d", d), 64'(ro[d]), 64'(e.res));
            chk($sformatf("tag_d%0d", d), 64'(tgo[d]), 64'(e.tag));
            chk($sformatf("latency_d%0d", d), 64'(cyc - e.acc), 64'(e.lat));
          end
        end
      end
    end
  end

  initial begin
    dir[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    dir[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
    dir[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
    dir[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
    dir[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
    dir[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
    dir[6]  = '{3'd5, 32'd100,        32'd7,         32'd14};
    dir[7]  = '{3'd7, 32'd100,        32'd7,         32'd2};
    dir[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF};
    dir[9]  = '{3'd6, 32'd5,          32'd0,         32'd5};
    dir[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
    dir[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_ready_d%0d", d), 64'(rdo[d]), 64'd1);
      chk($sformatf("reset_valid_d%0d", d), 64'(vo[d]), 64'd0);
      chk($sformatf("reset_result_d%0d", d), 64'(ro[d]), 64'd0);
      chk($sformatf("reset_tag_d%0d", d), 64'(tgo[d]), 64'd0);
    end

    bp_force = 1'b0;
    for (int i = 0; i < 12; i++)
      issue(dir[i].fn, dir[i].a, dir[i].b, 5'(i + 1), dir[i].res, 1'b1);

    for (int i = 0; i < 30; i++) begin
      logic [2:0]  fn;
      logic [31:0] a, b;
      fn = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      issue(fn, a, b, 5'($urandom_range(0, 31)), ref_model(fn, a, b), 1'b1);
    end
    drain();

    bp_force = 1'b1;
    bp_val   = 1'b0;
    issue(3'd5, 32'd100, 32'd7, 5'd9, 32'd14, 1'b1);
    begin
      int n;
      n = 0;
      while (!(vo[0] && vo[1]) && n < 60) begin
        @(negedge clk);
        n++;
      end
      chk("bp_valid_timeout", 64'(n >= 60), 64'd0);
    end
    for (int k = 0; k < 5; k++) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("bp_result_d%0d", d), 64'(ro[d]), 64'd14);
        chk($sformatf("bp_tag_d%0d", d), 64'(tgo[d]), 64'd9);
        chk($sformatf("bp_ready_low_d%0d", d), 64'(rdo[d]), 64'd0);
      end
      if (k < 4) @(negedge clk);
    end
    bp_val = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("bp_release_ready_d%0d", d), 64'(rdo[d]), 64'd1);
      chk($sformatf("bp_release_valid_d%0d", d), 64'(vo[d]), 64'd0);
    end
    drain();

    issue(3'd4, 32'd1000, 32'd7, 5'd4, 32'd0, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1; valid_i = 1'b1; funct3_i = 3'd5; op_a_i = 32'd50; op_b_i = 32'd5; tag_i = 5'd7;
    @(posedge clk);
    #1;
    flush_i = 1'b0; valid_i = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("flush_ready_d%0d", d), 64'(rdo[d]), 64'd1);
      chk($sformatf("flush_valid_d%0d", d), 64'(vo[d]), 64'd0);
    end
    @(negedge clk);
    flush_i = 1'b1; valid_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0; valid_i = 1'b0;
    watch_quiet("flush_no_result", 45);
    issue(3'd5, 32'd100, 32'd7, 5'd12, 32'd14, 1'b1);
    drain();

    issue(3'd4, 32'd1000, 32'd7, 5'd5, 32'd0, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; valid_i = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; valid_i = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_ready_d%0d", d), 64'(rdo[d]), 64'd1);
      chk($sformatf("rst_valid_d%0d", d), 64'(vo[d]), 64'd0);
      chk($sformatf("rst_result_d%0d", d), 64'(ro[d]), 64'd0);
      chk($sformatf("rst_tag_d%0d", d), 64'(tgo[d]), 64'd0);
    end
    watch_quiet("rst_no_result", 45);
    issue(3'd5, 32'd100, 32'd7, 5'd3, 32'd14, 1'b1);
    drain();

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
